// File: rtl/reg_scoreboard_pkg.sv
// Shared pipeline types for the 8-register core.
// Entry layout is reused by the ID/EX and MEM/WB latches.
package reg_scoreboard_pkg;

  localparam int REG_SEL_W = 3;
  localparam int NUM_REGS  = 2 ** REG_SEL_W;

  typedef logic [REG_SEL_W-1:0] reg_sel_t;
  typedef logic [NUM_REGS-1:0]  reg_mask_t;

  typedef struct packed {
    logic     valid;
    reg_sel_t rd;
  } sb_entry_t;

  localparam int SB_ENTRY_W = $bits(sb_entry_t);

  localparam sb_entry_t SB_ENTRY_NONE = '0;

  function automatic reg_mask_t sel_onehot(
    input reg_sel_t s
  );
    reg_mask_t m;
    m    = '0;
    m[s] = 1'b1;
    return m;
  endfunction

  function automatic logic entry_hits(
    input sb_entry_t e,
    input reg_sel_t  s
  );
    return e.valid && (e.rd == s);
  endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode-side view of the hazard scoreboard.
// master = decode/front end, slave = scoreboard.
interface reg_scoreboard_if;
  import reg_scoreboard_pkg::*;

  logic      id_valid;
  reg_sel_t  id_rs1_sel;
  logic      id_rs1_used;
  reg_sel_t  id_rs2_sel;
  logic      id_rs2_used;
  reg_sel_t  id_rd_sel;
  logic      id_rd_wr;
  logic      flush;
  logic      stall_ext;

  logic      stall;
  logic      issue;
  reg_mask_t pend_mask;
  logic      wb_pend_valid;
  reg_sel_t  wb_pend_sel;

  modport master (
    output id_valid,
    output id_rs1_sel,
    output id_rs1_used,
    output id_rs2_sel,
    output id_rs2_used,
    output id_rd_sel,
    output id_rd_wr,
    output flush,
    output stall_ext,
    input  stall,
    input  issue,
    input  pend_mask,
    input  wb_pend_valid,
    input  wb_pend_sel
  );

  modport slave (
    input  id_valid,
    input  id_rs1_sel,
    input  id_rs1_used,
    input  id_rs2_sel,
    input  id_rs2_used,
    input  id_rd_sel,
    input  id_rd_wr,
    input  flush,
    input  stall_ext,
    output stall,
    output issue,
    output pend_mask,
    output wb_pend_valid,
    output wb_pend_sel
  );

endinterface

// File: rtl/reg_scoreboard_sb_stage.sv
// One scoreboard shadow entry {valid, rd}.
// Holds while disabled; exposes a one-hot of its destination.
module sb_stage
  import reg_scoreboard_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      en,
  input  sb_entry_t d,
  output sb_entry_t q,
  output reg_mask_t onehot
);

  // entry register, frozen when the pipeline is frozen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SB_ENTRY_NONE;
    end else if (en) begin
      q <= d;
    end
  end

  // invalid entries contribute nothing to the pending mask
  always_comb begin
    onehot = '0;
    if (q.valid) begin
      onehot = sel_onehot(q.rd);
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Decode-stage RAW hazard scoreboard tracking EX/MEM/WB.
// WB producers are covered by the RF bypass and never stall.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  reg_scoreboard_if.slave  sb
);

  logic      en;
  sb_entry_t ex_d;
  sb_entry_t ex_q;
  sb_entry_t mem_q;
  sb_entry_t wb_q;
  reg_mask_t ex_oh;
  reg_mask_t mem_oh;
  reg_mask_t wb_oh;
  logic      rs1_hit;
  logic      rs2_hit;
  logic      hazard;
  logic      stall;
  logic      issue;

  assign en = ~sb.stall_ext;

  // only EX and MEM producers are compared; decode's own
  // rd is never compared against its own sources
  always_comb begin
    rs1_hit = sb.id_rs1_used
            & ( entry_hits(ex_q,  sb.id_rs1_sel)
              | entry_hits(mem_q, sb.id_rs1_sel));
    rs2_hit = sb.id_rs2_used
            & ( entry_hits(ex_q,  sb.id_rs2_sel)
              | entry_hits(mem_q, sb.id_rs2_sel));
    hazard  = sb.id_valid & (rs1_hit | rs2_hit);
  end

  // flush beats a hazard stall; a memory stall beats all
  always_comb begin
    stall = sb.stall_ext | (hazard & ~sb.flush);
    issue = sb.id_valid & ~stall & ~sb.flush;
  end

  // next EX entry; anything that does not issue is a bubble
  always_comb begin
    ex_d       = SB_ENTRY_NONE;
    ex_d.valid = issue & sb.id_rd_wr;
    ex_d.rd    = sb.id_rd_sel;
  end

  sb_stage u_ex (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .d      (ex_d),
    .q      (ex_q),
    .onehot (ex_oh)
  );

  sb_stage u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .d      (ex_q),
    .q      (mem_q),
    .onehot (mem_oh)
  );

  sb_stage u_wb (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .d      (mem_q),
    .q      (wb_q),
    .onehot (wb_oh)
  );

  assign sb.stall         = stall;
  assign sb.issue         = issue;
  assign sb.pend_mask     = ex_oh | mem_oh | wb_oh;
  assign sb.wb_pend_valid = wb_q.valid;
  assign sb.wb_pend_sel   = wb_q.rd;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed table, async
// reset sequence, and randomized run against a model.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  typedef struct {
    logic       rst_n;
    logic       v;
    logic [2:0] rs1;
    logic       u1;
    logic [2:0] rs2;
    logic       u2;
    logic [2:0] rd;
    logic       wr;
    logic       fl;
    logic       sx;
    logic       e_stall;
    logic       e_issue;
    logic [7:0] e_pm;
    logic       e_wbv;
    logic [2:0] e_wbs;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs[$];

  int   m_rd[$];
  int   m_age[$];

  always #5 clk = ~clk;

  reg_scoreboard_if sbi ();

  reg_scoreboard dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sbi)
  );

  function automatic vec_t mk(
    input logic r, v,
    input int rs1, input logic u1,
    input int rs2, input logic u2,
    input int rd, input logic wr, fl, sx,
    input logic st, is,
    input int pm,
    input logic wbv,
    input int wbs
  );
    vec_t t;
    t.rst_n = r;   t.v = v;
    t.rs1 = 3'(rs1); t.u1 = u1;
    t.rs2 = 3'(rs2); t.u2 = u2;
    t.rd = 3'(rd);   t.wr = wr;
    t.fl = fl;       t.sx = sx;
    t.e_stall = st;  t.e_issue = is;
    t.e_pm = 8'(pm); t.e_wbv = wbv;
    t.e_wbs = 3'(wbs);
    return t;
  endfunction

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  task automatic drive(
    input logic v, input int rs1, input logic u1,
    input int rs2, input logic u2,
    input int rd, input logic wr, fl, sx
  );
    sbi.id_valid    = v;
    sbi.id_rs1_sel  = 3'(rs1);
    sbi.id_rs1_used = u1;
    sbi.id_rs2_sel  = 3'(rs2);
    sbi.id_rs2_used = u2;
    sbi.id_rd_sel   = 3'(rd);
    sbi.id_rd_wr    = wr;
    sbi.flush       = fl;
    sbi.stall_ext   = sx;
  endtask

  // reference: producers are listed with the number of
  // clock edges since they issued (1=EX, 2=MEM, 3=WB)
  function automatic logic m_busy(input int s);
    for (int k = 0; k < m_rd.size(); k++)
      if (m_rd[k] == s && m_age[k] <= 2) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_mask();
    int m = 0;
    for (int k = 0; k < m_rd.size(); k++)
      m |= (1 << m_rd[k]);
    return m;
  endfunction

  function automatic int m_wb_idx();
    for (int k = 0; k < m_rd.size(); k++)
      if (m_age[k] == 3) return k;
    return -1;
  endfunction

  task automatic m_edge(input logic sx, iss, wr,
                        input int rd);
    int nrd[$];
    int nage[$];
    if (sx) return;
    for (int k = 0; k < m_rd.size(); k++)
      if (m_age[k] < 3) begin
        nrd.push_back(m_rd[k]);
        nage.push_back(m_age[k] + 1);
      end
    if (iss && wr) begin
      nrd.push_back(rd);
      nage.push_back(1);
    end
    m_rd  = nrd;
    m_age = nage;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // r  v rs1 u1 rs2 u2 rd wr fl sx | st is pm wbv wbs
    vecs.push_back(mk(0,1,0,0,0,0,0,0,0,0, 0,1,'h00,0,0));
    vecs.push_back(mk(1,1,0,0,0,0,3,1,0,0, 0,1,'h00,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0, 0,0,'h08,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0, 0,0,'h08,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0, 0,0,'h08,1,3));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0, 0,0,'h00,0,0));
    vecs.push_back(mk(1,1,0,0,0,0,2,1,0,0, 0,1,'h00,0,0));
    vecs.push_back(mk(1,1,2,1,0,0,0,0,0,0, 1,0,'h04,0,0));
    vecs.push_back(mk(1,1,2,1,0,0,0,0,0,0, 1,0,'h04,0,0));
    vecs.push_back(mk(1,1,2,1,0,0,0,0,0,0, 0,1,'h04,1,2));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0, 0,0,'h00,0,0));
    vecs.push_back(mk(1,1,0,0,0,0,6,1,0,0, 0,1,'h00,0,0));
    vecs.push_back(mk(1,1,6,0,6,0,0,0,0,0, 0,1,'h40,0,0));
    vecs.push_back(mk(1,1,6,0,6,1,0,0,0,0, 1,0,'h40,0,0));
    vecs.push_back(mk(1,1,6,0,6,1,0,0,0,0, 0,1,'h40,1,6));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0, 0,0,'h00,0,0));
    vecs.push_back(mk(1,1,0,0,0,0,5,1,0,0, 0,1,'h00,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0, 0,0,'h20,0,0));
    vecs.push_back(mk(1,1,0,0,0,0,7,1,0,1, 1,0,'h20,0,0));
    vecs.push_back(mk(1,1,0,0,0,0,7,1,0,1, 1,0,'h20,0,0));
    vecs.push_back(mk(1,1,0,0,0,0,7,1,0,1, 1,0,'h20,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0, 0,0,'h20,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0, 0,0,'h20,1,5));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0, 0,0,'h00,0,0));
    vecs.push_back(mk(1,1,0,0,0,0,1,1,0,0, 0,1,'h00,0,0));
    vecs.push_back(mk(1,1,1,1,0,0,7,1,0,0, 1,0,'h02,0,0));
    vecs.push_back(mk(1,1,1,1,0,0,7,1,1,0, 0,0,'h02,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0, 0,0,'h02,1,1));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0, 0,0,'h00,0,7));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n;
      drive(vecs[i].v, vecs[i].rs1, vecs[i].u1,
            vecs[i].rs2, vecs[i].u2, vecs[i].rd,
            vecs[i].wr, vecs[i].fl, vecs[i].sx);
      #1;
      chk($sformatf("row%0d stall", i),
          sbi.stall, vecs[i].e_stall);
      chk($sformatf("row%0d issue", i),
          sbi.issue, vecs[i].e_issue);
      chk($sformatf("row%0d pend_mask", i),
          sbi.pend_mask, vecs[i].e_pm);
      chk($sformatf("row%0d wb_pend_valid", i),
          sbi.wb_pend_valid, vecs[i].e_wbv);
      chk($sformatf("row%0d wb_pend_sel", i),
          sbi.wb_pend_sel, vecs[i].e_wbs);
    end

    // async reset mid-stall: r1 in EX, r4 in MEM
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 4, 1, 0, 0);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0);
    @(negedge clk);
    drive(1, 4, 1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("pre_rst stall", sbi.stall, 1'b1);
    chk("pre_rst pend_mask", sbi.pend_mask, 8'h12);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst stall", sbi.stall, 1'b0);
    chk("async_rst issue", sbi.issue, 1'b1);
    chk("async_rst pend_mask", sbi.pend_mask, 8'h00);
    chk("async_rst wb_pend_valid",
        sbi.wb_pend_valid, 1'b0);
    chk("async_rst wb_pend_sel", sbi.wb_pend_sel, 3'd0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("rst_sx stall", sbi.stall, 1'b1);
    chk("rst_sx issue", sbi.issue, 1'b0);
    drive(1, 4, 1, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst stall", sbi.stall, 1'b0);
    chk("post_rst issue", sbi.issue, 1'b1);
    chk("post_rst pend_mask", sbi.pend_mask, 8'h00);

    // randomized run against the producer-age model
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    m_rd.delete();
    m_age.delete();
    for (int n = 0; n < 3000; n++) begin
      logic v, u1, u2, wr, fl, sx;
      logic haz, e_st, e_is;
      int   rs1, rs2, rd, wi;
      @(negedge clk);
      v   = ($urandom_range(7) != 0);
      u1  = $urandom_range(1);
      u2  = $urandom_range(1);
      wr  = ($urandom_range(3) != 0);
      fl  = ($urandom_range(7) == 0);
      sx  = ($urandom_range(7) == 0);
      rs1 = $urandom_range(7);
      rs2 = $urandom_range(7);
      rd  = $urandom_range(7);
      drive(v, rs1, u1, rs2, u2, rd, wr, fl, sx);
      haz  = v & ((u1 & m_busy(rs1)) |
                  (u2 & m_busy(rs2)));
      e_st = sx | (haz & ~fl);
      e_is = v & ~e_st & ~fl;
      wi   = m_wb_idx();
      #1;
      chk($sformatf("rnd%0d stall", n), sbi.stall, e_st);
      chk($sformatf("rnd%0d issue", n), sbi.issue, e_is);
      chk($sformatf("rnd%0d pend_mask", n),
          sbi.pend_mask, 32'(m_mask()));
      chk($sformatf("rnd%0d wb_pend_valid", n),
          sbi.wb_pend_valid, (wi >= 0));
      if (wi >= 0)
        chk($sformatf("rnd%0d wb_pend_sel", n),
            sbi.wb_pend_sel, 32'(m_rd[wi]));
      m_edge(sx, e_is, wr, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Decode-stage hazard scoreboard for the 16-bit, 8-register pipelined core. It tracks the destination register of every instruction in EX, MEM and WB and stalls the decode stage while a source operand is still in flight. The register file's same-cycle write-to-read bypass serves only the WB-stage producer, so this block must stall any consumer whose producer is still in EX or MEM. It sits between the IF/ID latch (which it holds) and the ID/EX latch (into which it inserts bubbles).

## Interface
Parameters:
- REG_SEL_W, 3, register-select width
- NUM_REGS, 8, number of architectural registers (2**REG_SEL_W)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  decode holds a valid instruction
- id_rs1_sel  in  REG_SEL_W  source 1 select
- id_rs1_used  in  1  instruction reads rs1
- id_rs2_sel  in  REG_SEL_W  source 2 select
- id_rs2_used  in  1  instruction reads rs2
- id_rd_sel  in  REG_SEL_W  destination select
- id_rd_wr  in  1  instruction writes rd
- flush  in  1  squash the instruction currently in decode (branch resolved taken)
- stall_ext  in  1  memory stall; freeze the whole pipeline
- stall  out  1  hold PC and the IF/ID latch
- issue  out  1  decode instruction advances into EX this cycle
- pend_mask  out  NUM_REGS  bit r set if any valid EX/MEM/WB entry targets register r
- wb_pend_valid  out  1  WB entry valid; the RF write is expected this cycle
- wb_pend_sel  out  REG_SEL_W  WB entry destination, compared against the RF write select

## Operation
- State: three shadow entries, ex_q, mem_q and wb_q. Each entry is {valid, rd}.
- match(s) = (ex_q.valid & ex_q.rd==s) | (mem_q.valid & mem_q.rd==s). The wb_q entry is excluded because the RF bypass covers it.
- hazard = id_valid & ((id_rs1_used & match(id_rs1_sel)) | (id_rs2_used & match(id_rs2_sel)))
- stall = stall_ext | (hazard & ~flush)
- issue = id_valid & ~stall & ~flush
- Clock edge with stall_ext=0:
  - wb_q <= mem_q
  - mem_q <= ex_q
  - ex_q <= {issue & id_rd_wr, id_rd_sel}. When the instruction does not issue, a bubble (valid=0) is inserted.
- Clock edge with stall_ext=1: all entries hold. stall=1 and issue=0.
- flush with hazard: flush wins. stall=0 (unless stall_ext), issue=0, and a bubble enters EX.
- flush together with stall_ext: entries hold. The flush request is the front end's responsibility to re-present after stall_ext drops.
- A producer and a consumer with the same register in decode (rd==rs) cause no self-hazard. Only older entries are compared.
- A source with _used=0 never stalls, even if its select matches.
- pend_mask = OR of the one-hot decode of each valid entry. Duplicate destinations simply OR together.
- wb_pend_valid and wb_pend_sel come directly from wb_q.

## Timing
- Reset (rst_n low, asynchronous): all entries are invalid, pend_mask=0, wb_pend_valid=0, wb_pend_sel=0.
- With reset asserted, stall = stall_ext and issue = id_valid & ~stall_ext & ~flush.
- Reset mid-operation clears in-flight entries immediately. No stale stall survives past deassertion.
- stall and issue are combinational from the current-cycle inputs and state, with zero latency.
- Producer timeline: a producer issued at cycle t occupies EX at t+1, MEM at t+2 and WB at t+3.
- A dependent instruction in decode at t+1 stalls during t+1 and t+2, issues at t+3, and reads the data through the RF bypass. This gives a 2-bubble penalty.
- A dependent at distance 2 stalls 1 cycle. At distance 3 or more it does not stall.

## Structure
- Shared pipeline package/header holds REG_SEL_W, NUM_REGS and the entry layout {valid, rd} with its width constant. These are reused by the ID/EX and MEM/WB latches.
- One sub-module, sb_stage: a single entry register with async active-low reset, an enable (~stall_ext) and a one-hot decode output.
- reg_scoreboard instantiates sb_stage three times and adds the compare, stall and issue logic.

## Test plan
- Reset: rst_n low with id_valid=1 and no sources used -> pend_mask=0, stall=0, issue=1. After release, issue a write to r3 -> pend_mask=0x08 for 3 cycles, then 0.
- RAW distance 1: issue a write to r2, next cycle a read of rs1=r2 -> stall=1 for 2 cycles, issue=1 on the 3rd cycle, when wb_pend_valid=1 and wb_pend_sel=2.
- RAW distance 2 on rs2 with rs1 unused but matching -> only the rs2 match stalls, for 1 cycle. A matching select with _used=0 alone gives stall=0.
- stall_ext held 3 cycles with r5 in MEM -> entries frozen, pend_mask stays 0x20, issue=0. After release, r5 moves to WB the next cycle.
- flush during a hazard stall -> stall=0, issue=0, a bubble enters EX, and pend_mask gains no new bit.
- Async reset asserted mid-stall with r1 in EX and r4 in MEM -> pend_mask=0 and stall=0 within the same cycle, before any clock edge.
